// File: rtl/dm_responder_if.sv
// dm_responder_if: request/response handshake bundle between initiator and responder
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: single-outstanding word memory responder with fixed response latency
module dm_responder #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input logic          clk,
  input logic          reset,
  dm_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic              up;
  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept;
  logic              addr_err;
  logic [ADDR_W-1:0] idx;
  assign accept   = bus.req_ready && bus.req_valid;
  assign addr_err = |bus.req_addr[1:0] || |(bus.req_addr >> (ADDR_W + 2));
  assign idx      = bus.req_addr[ADDR_W+1:2];
  // state, latency counter and post-reset ready flag; ready stays low until the first edge after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      up    <= 1'b0;
    end else begin
      up    <= 1'b1;
      state <= state_nx;
      cnt   <= (state == IDLE && accept) ? 4'(LATENCY - 1) : (state == WAIT) ? cnt - 4'd1 : cnt;
    end
  end
  // next state: leave WAIT on the edge the counter reaches zero
  always_comb begin
    state_nx = (state == IDLE) ? (accept ? ((LATENCY == 1) ? RESP : WAIT) : IDLE) :
               (state == WAIT) ? ((cnt == 4'd1) ? RESP : WAIT) :
               (bus.resp_ready ? IDLE : RESP);
  end
  // handshake outputs; response payload only driven while presented
  always_comb begin
    bus.req_ready  = up && state == IDLE;
    bus.resp_valid = state == RESP;
    bus.resp_rdata = (state == RESP) ? rdata_q : '0;
    bus.resp_err   = (state == RESP) && err_q;
  end
  // capture the response at acceptance so later stores cannot disturb a pending load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= addr_err;
      rdata_q <= (bus.req_we || addr_err) ? '0 : mem[idx];
    end
  end
  // byte-masked store committed at acceptance; array is never reset
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !addr_err)
      for (int i = 0; i < 4; i++)
        if (bus.req_be[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
  end
endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter LATENCY, default 2: cycles from request acceptance to resp_valid assertion; legal range 1..15.
REQ-002 Parameter ADDR_W, default 10: log2 of word depth; array holds 2^ADDR_W 32-bit words.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_be  input  4  store byte enables; bit i covers bits [8i+7:8i]; ignored for loads.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 resp_valid  output  1  response held for initiator.
REQ-012 resp_ready  input  1  initiator consumes response this cycle.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 States IDLE, WAIT, RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-016 Acceptance: rising edge with state IDLE and req_valid=1; all req_* fields sampled at that edge only.
REQ-017 Error: req_addr[1:0]!=0 or req_addr[31:ADDR_W+2]!=0 sets resp_err=1 for that response; array unchanged.
REQ-018 Word index = req_addr[ADDR_W+1:2].
REQ-019 Store without error: at the acceptance edge, bytes with req_be[i]=1 take req_wdata; other bytes keep old value; req_be=0000 writes nothing and still returns a response.
REQ-020 Load without error: array word read at the acceptance edge, registered, presented on resp_rdata; a store accepted later cannot alter it.
REQ-021 Transitions: IDLE->RESP on acceptance if LATENCY=1, else IDLE->WAIT with counter loaded to LATENCY-1.
REQ-022 WAIT: counter decrements each cycle; WAIT->RESP on the edge the counter goes 1->0.
REQ-023 resp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-024 RESP: resp_valid, resp_rdata, resp_err held stable until resp_ready=1; RESP->IDLE on that edge.
REQ-025 Minimum request spacing is LATENCY+1 cycles; no request accepted while in WAIT or RESP, regardless of req_valid.
REQ-026 resp_ready=1 outside RESP has no effect; req_valid may be dropped by the initiator before acceptance without effect.
REQ-027 Asynchronous reset during WAIT or RESP discards the pending response; any store already committed at acceptance remains in the array.

Reset
REQ-028 While reset=0: state IDLE, counter 0, req_ready=1 is not required (req_ready=0), resp_valid=0, resp_rdata=0, resp_err=0.
REQ-029 On first rising edge after reset returns to 1, state IDLE with req_ready=1; array contents are not reset.

Verification
REQ-030 LATENCY=2: store addr 0x0000_0010, be=1111, data 0xDEAD_BEEF accepted at edge T -> resp_valid at T+2, rdata=0, err=0; load 0x10 -> rdata 0xDEAD_BEEF.
REQ-031 Byte enables: store 0x1122_3344 be=1111 to 0x20, then store 0xAABB_CCDD be=0101 -> load 0x20 returns 0x11BB_33DD.
REQ-032 Errors: load 0x0000_0013 -> err=1, rdata=0; store to 0x0000_1000 (ADDR_W=10) -> err=1, subsequent load 0x0 unaffected.
REQ-033 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0 throughout; req_valid held high meanwhile is accepted only on the first IDLE cycle after resp_ready=1.
REQ-034 Reset mid-WAIT: accept load, assert reset=0 one cycle later -> resp_valid never rises, outputs 0; after release a new load completes normally.
REQ-035 LATENCY=1 and LATENCY=15 builds: resp_valid asserted exactly 1 and 15 cycles after acceptance.
